// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : trap_ctrl_pkg
// Brief   : Exception classes, cause codes, CSR addresses, privilege levels
//           and mstatus update helpers shared by the trap sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

    // Exception classification from the EXE checker
    localparam logic [1:0] EXP_NONE = 2'd0;
    localparam logic [1:0] EXP_OP   = 2'd1;
    localparam logic [1:0] EXP_ERR  = 2'd2;

    // Synchronous exception cause codes
    localparam logic [3:0] EXP_INST_MISALIGN    = 4'd0;
    localparam logic [3:0] EXP_INST_FAULT       = 4'd1;
    localparam logic [3:0] EXP_ILLEGAL_INST     = 4'd2;
    localparam logic [3:0] EXP_BREAKPOINT       = 4'd3;
    localparam logic [3:0] EXP_LOAD_MISALIGN    = 4'd4;
    localparam logic [3:0] EXP_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] EXP_STORE_MISALIGN   = 4'd6;
    localparam logic [3:0] EXP_STORE_FAULT      = 4'd7;
    localparam logic [3:0] EXP_ECALL_U          = 4'd8;
    localparam logic [3:0] EXP_ECALL_M          = 4'd11;
    localparam logic [3:0] EXP_INST_PAGE_FAULT  = 4'd12;
    localparam logic [3:0] EXP_LOAD_PAGE_FAULT  = 4'd13;
    localparam logic [3:0] EXP_NO_CAUSE         = 4'd14;
    localparam logic [3:0] EXP_STORE_PAGE_FAULT = 4'd15;

    // inst[31:7] of the system instructions that raise EXP_OP
    localparam logic [24:0] ECALL_PREFIX  = 25'h0000000;
    localparam logic [24:0] EBREAK_PREFIX = 25'h0002000;
    localparam logic [24:0] MRET_PREFIX   = 25'h0604000;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [1:0] PRV_U = 2'b00;
    localparam logic [1:0] PRV_M = 2'b11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_W_MEPC    = 3'd1,
        ST_W_MCAUSE  = 3'd2,
        ST_W_MTVAL   = 3'd3,
        ST_W_MSTATUS = 3'd4,
        ST_W_MRET    = 3'd5,
        ST_REDIRECT  = 3'd6
    } trap_state_e;

    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms,
                                                    input logic [1:0]  cur_priv);
        logic [31:0] r;
        r                                  = ms;
        r[MSTATUS_MPIE]                    = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]                     = 1'b0;
        r[MSTATUS_MPP+1:MSTATUS_MPP]       = cur_priv;
        return r;
    endfunction

    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
        logic [31:0] r;
        r                                  = ms;
        r[MSTATUS_MIE]                     = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE]                    = 1'b1;
        r[MSTATUS_MPP+1:MSTATUS_MPP]       = PRV_U;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : trap_ctrl_if
// Brief     : EXE-stage exception inputs, CSR write port and fetch redirect
//             bundle between the pipeline and the trap sequencer.
// Rev       : 1.0 - initial release
// ============================================================================
interface trap_ctrl_if #(
    parameter int XLEN = 32
);
    logic            exp_valid;
    logic [1:0]      exception;
    logic [3:0]      exp_code;
    logic [XLEN-1:0] exp_pc;
    logic [31:0]     exp_inst;
    logic [XLEN-1:0] exp_badaddr;
    logic [XLEN-1:0] mtvec_i;
    logic [XLEN-1:0] mepc_i;
    logic [XLEN-1:0] mstatus_i;

    logic            csr_we;
    logic [11:0]     csr_waddr;
    logic [XLEN-1:0] csr_wdata;
    logic            stall;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      priv;

    // Pipeline side
    modport master (
        output exp_valid, exception, exp_code, exp_pc, exp_inst, exp_badaddr,
        output mtvec_i, mepc_i, mstatus_i,
        input  csr_we, csr_waddr, csr_wdata, stall, flush,
        input  redirect_valid, redirect_pc, priv
    );

    // Trap sequencer side
    modport slave (
        input  exp_valid, exception, exp_code, exp_pc, exp_inst, exp_badaddr,
        input  mtvec_i, mepc_i, mstatus_i,
        output csr_we, csr_waddr, csr_wdata, stall, flush,
        output redirect_valid, redirect_pc, priv
    );
endinterface
`default_nettype wire

// File: rtl/trap_cause_enc.sv
`default_nettype none
// ============================================================================
// Module : trap_cause_enc
// Brief  : Combinational classifier: decides whether the EXE instruction
//          requests a trap or an MRET, and resolves mcause and mtval.
// Rev    : 1.0 - initial release
// ============================================================================
module trap_cause_enc
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [1:0]      exception,
    input  wire logic [3:0]      exp_code,
    input  wire logic [31:0]     inst,
    input  wire logic [1:0]      priv,
    input  wire logic [XLEN-1:0] pc,
    input  wire logic [XLEN-1:0] badaddr,
    output logic                 req,
    output logic                 mret,
    output logic [3:0]           cause,
    output logic [XLEN-1:0]      mtval
);

    logic w_is_ecall;
    logic w_is_ebreak;
    logic w_is_mret;

    assign w_is_ecall  = (inst[31:7] == ECALL_PREFIX);
    assign w_is_ebreak = (inst[31:7] == EBREAK_PREFIX);
    assign w_is_mret   = (inst[31:7] == MRET_PREFIX);

    always_comb begin
        req   = 1'b0;
        mret  = 1'b0;
        cause = EXP_NO_CAUSE;
        case (exception)
            EXP_ERR: begin
                if (exp_code != EXP_NO_CAUSE) begin
                    req   = 1'b1;
                    cause = exp_code;
                end
            end
            EXP_OP: begin
                if (w_is_ecall) begin
                    req   = 1'b1;
                    cause = (priv == PRV_U) ? EXP_ECALL_U : EXP_ECALL_M;
                end else if (w_is_ebreak) begin
                    req   = 1'b1;
                    cause = EXP_BREAKPOINT;
                end else if (w_is_mret) begin
                    req = 1'b1;
                    // MRET from user mode is an illegal instruction
                    if (priv == PRV_M) begin
                        mret = 1'b1;
                    end else begin
                        cause = EXP_ILLEGAL_INST;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        mtval = '0;
        case (cause)
            EXP_LOAD_MISALIGN, EXP_LOAD_FAULT, EXP_STORE_MISALIGN,
            EXP_STORE_FAULT, EXP_LOAD_PAGE_FAULT, EXP_STORE_PAGE_FAULT:
                mtval = badaddr;
            EXP_ILLEGAL_INST:
                mtval = inst;
            EXP_BREAKPOINT:
                mtval = pc;
            default:
                mtval = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module : trap_ctrl
// Brief  : Multi-cycle trap/MRET sequencer: stalls the pipeline, writes the
//          machine trap CSRs one per cycle, then flushes and redirects fetch.
// Rev    : 1.0 - initial release
// ============================================================================
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
    trap_ctrl_if.slave bus
);

    trap_state_e     r_state;
    trap_state_e     w_state_next;
    logic [1:0]      r_priv;
    logic [XLEN-1:0] r_pc;
    logic [3:0]      r_cause;
    logic [XLEN-1:0] r_mtval;
    logic            r_is_mret;

    logic            w_enc_req;
    logic            w_enc_mret;
    logic [3:0]      w_enc_cause;
    logic [XLEN-1:0] w_enc_mtval;
    logic            w_req;

    logic            w_csr_we;
    logic [11:0]     w_csr_waddr;
    logic [XLEN-1:0] w_csr_wdata;
    logic            w_stall;
    logic            w_flush;
    logic            w_redirect_valid;
    logic [XLEN-1:0] w_redirect_pc;

    trap_cause_enc #(
        .XLEN (XLEN)
    ) u_cause_enc (
        .exception (bus.exception),
        .exp_code  (bus.exp_code),
        .inst      (bus.exp_inst),
        .priv      (r_priv),
        .pc        (bus.exp_pc),
        .badaddr   (bus.exp_badaddr),
        .req       (w_enc_req),
        .mret      (w_enc_mret),
        .cause     (w_enc_cause),
        .mtval     (w_enc_mtval)
    );

    // Held-off while reset is asserted so every output reads zero in reset
    assign w_req = bus.exp_valid & w_enc_req & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_priv    <= PRV_M;
            r_pc      <= '0;
            r_cause   <= '0;
            r_mtval   <= '0;
            r_is_mret <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && w_req) begin
                r_pc      <= bus.exp_pc;
                r_cause   <= w_enc_cause;
                r_mtval   <= w_enc_mtval;
                r_is_mret <= w_enc_mret;
            end
            if (r_state == ST_W_MSTATUS) begin
                r_priv <= PRV_M;
            end else if (r_state == ST_W_MRET) begin
                r_priv <= bus.mstatus_i[MSTATUS_MPP+1:MSTATUS_MPP];
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_csr_we         = 1'b0;
        w_csr_waddr      = '0;
        w_csr_wdata      = '0;
        w_stall          = 1'b0;
        w_flush          = 1'b0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_stall      = 1'b1;
                    w_state_next = w_enc_mret ? ST_W_MRET : ST_W_MEPC;
                end
            end
            ST_W_MEPC: begin
                w_stall      = 1'b1;
                w_csr_we     = 1'b1;
                w_csr_waddr  = CSR_MEPC;
                w_csr_wdata  = {r_pc[XLEN-1:2], 2'b00};
                w_state_next = ST_W_MCAUSE;
            end
            ST_W_MCAUSE: begin
                w_stall      = 1'b1;
                w_csr_we     = 1'b1;
                w_csr_waddr  = CSR_MCAUSE;
                w_csr_wdata  = {{(XLEN-4){1'b0}}, r_cause};
                w_state_next = ST_W_MTVAL;
            end
            ST_W_MTVAL: begin
                w_stall      = 1'b1;
                w_csr_we     = 1'b1;
                w_csr_waddr  = CSR_MTVAL;
                w_csr_wdata  = r_mtval;
                w_state_next = ST_W_MSTATUS;
            end
            ST_W_MSTATUS: begin
                w_stall      = 1'b1;
                w_csr_we     = 1'b1;
                w_csr_waddr  = CSR_MSTATUS;
                w_csr_wdata  = mstatus_on_trap(bus.mstatus_i, r_priv);
                w_state_next = ST_REDIRECT;
            end
            ST_W_MRET: begin
                w_stall      = 1'b1;
                w_csr_we     = 1'b1;
                w_csr_waddr  = CSR_MSTATUS;
                w_csr_wdata  = mstatus_on_mret(bus.mstatus_i);
                w_state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                w_flush          = 1'b1;
                w_redirect_valid = 1'b1;
                w_redirect_pc    = r_is_mret ? bus.mepc_i
                                             : {bus.mtvec_i[XLEN-1:2], 2'b00};
                w_state_next     = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.csr_we         = w_csr_we;
    assign bus.csr_waddr      = w_csr_waddr;
    assign bus.csr_wdata      = w_csr_wdata;
    assign bus.stall          = w_stall;
    assign bus.flush          = w_flush;
    assign bus.redirect_valid = w_redirect_valid;
    assign bus.redirect_pc    = w_redirect_pc;
    assign bus.priv           = r_priv;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_trap_ctrl
// Brief  : Self-checking bench for trap_ctrl: directed scenarios plus random
//          requests compared against a behavioural trap model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trap_ctrl_if ifc ();

    trap_ctrl #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int total = 0;
    int bad   = 0;

    // Observed sequence of one request
    int          obs_n;
    logic [11:0] obs_addr [8];
    logic [31:0] obs_data [8];
    int          obs_wcyc [8];
    int          obs_rcyc;
    logic [31:0] obs_rpc;
    logic        obs_stall0;
    logic        obs_shape_ok;
    int          obs_pulses;
    logic [1:0]  obs_priv;

    // Reference model expectations
    int          exp_n;
    logic [11:0] exp_addr [4];
    logic [31:0] exp_data [4];
    int          exp_rcyc;
    logic [31:0] exp_rpc;
    logic        exp_stall0;
    logic [1:0]  exp_priv;
    logic [1:0]  mdl_priv;

    localparam logic [31:0] I_ECALL  = 32'h00000073;
    localparam logic [31:0] I_EBREAK = 32'h00100073;
    localparam logic [31:0] I_MRET   = 32'h30200073;
    localparam logic [31:0] I_CSRRW  = 32'h34011073;

    task automatic drive_req(input logic v, input logic [1:0] exc, input logic [3:0] code,
                             input logic [31:0] pc, inst, addr, ms, tvec, epc);
        obs_n = 0; obs_rcyc = -1; obs_rpc = '0; obs_shape_ok = 1'b1; obs_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            obs_addr[i] = '0; obs_data[i] = '0; obs_wcyc[i] = 0;
        end
        @(negedge clk);
        ifc.exp_valid = v; ifc.exception = exc; ifc.exp_code = code;
        ifc.exp_pc = pc; ifc.exp_inst = inst; ifc.exp_badaddr = addr;
        ifc.mstatus_i = ms; ifc.mtvec_i = tvec; ifc.mepc_i = epc;
        #1 obs_stall0 = ifc.stall;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            // Scramble the EXE fields: the sequencer must use its latched copies
            ifc.exp_valid = 1'b0; ifc.exp_code = 4'($urandom);
            ifc.exp_pc = $urandom; ifc.exp_inst = $urandom; ifc.exp_badaddr = $urandom;
            #1;
            if (ifc.csr_we && obs_n < 8) begin
                obs_addr[obs_n] = ifc.csr_waddr; obs_data[obs_n] = ifc.csr_wdata;
                obs_wcyc[obs_n] = c; obs_n++;
            end
            if (ifc.redirect_valid) begin
                obs_pulses++;
                if (obs_rcyc < 0) begin obs_rcyc = c; obs_rpc = ifc.redirect_pc; end
            end
            if (ifc.flush !== ifc.redirect_valid) obs_shape_ok = 1'b0;
            if (ifc.stall !== ifc.csr_we) obs_shape_ok = 1'b0;
        end
        obs_priv = ifc.priv;
    endtask

    task automatic model(input logic v, input logic [1:0] exc, input logic [3:0] code,
                         input logic [31:0] pc, inst, addr, ms, tvec, epc);
        logic trap, ret;
        logic [3:0] cause;
        logic [31:0] tval, op;
        trap = 1'b0; ret = 1'b0; cause = 4'd0; tval = '0;
        exp_n = 0; exp_rcyc = -1; exp_rpc = '0; exp_stall0 = 1'b0;
        op = inst >> 7;
        if (v && exc == EXP_ERR && code != 4'hE) begin
            trap = 1'b1; cause = code;
        end else if (v && exc == EXP_OP) begin
            if (op == 32'h0) begin trap = 1'b1; cause = (mdl_priv == 2'b00) ? 4'd8 : 4'd11; end
            else if (op == 32'h2000) begin trap = 1'b1; cause = 4'd3; end
            else if (op == 32'h604000) begin
                if (mdl_priv == 2'b11) ret = 1'b1;
                else begin trap = 1'b1; cause = 4'd2; end
            end
        end
        if (cause inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd13, 4'd15}) tval = addr;
        else if (cause == 4'd2) tval = inst;
        else if (cause == 4'd3) tval = pc;
        if (trap) begin
            exp_stall0 = 1'b1; exp_n = 4; exp_rcyc = 5; exp_rpc = tvec & ~32'h3;
            exp_addr[0] = 12'h341; exp_data[0] = pc & ~32'h3;
            exp_addr[1] = 12'h342; exp_data[1] = 32'(cause);
            exp_addr[2] = 12'h343; exp_data[2] = tval;
            exp_addr[3] = 12'h300;
            exp_data[3] = (ms & ~32'h1888) | (ms[3] ? 32'h80 : 32'h0) | (32'(mdl_priv) << 11);
            mdl_priv = 2'b11;
        end else if (ret) begin
            exp_stall0 = 1'b1; exp_n = 1; exp_rcyc = 2; exp_rpc = epc;
            exp_addr[0] = 12'h300;
            exp_data[0] = (ms & ~32'h1888) | 32'h80 | (ms[7] ? 32'h8 : 32'h0);
            mdl_priv = ms[12:11];
        end
        exp_priv = mdl_priv;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ifc.exp_valid = 1'b1; ifc.exception = EXP_OP; ifc.exp_code = 4'hE;
        ifc.exp_pc = 32'h80000000; ifc.exp_inst = I_ECALL; ifc.exp_badaddr = '0;
        ifc.mtvec_i = '0; ifc.mepc_i = '0; ifc.mstatus_i = '0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({ifc.csr_we, ifc.stall, ifc.flush, ifc.redirect_valid} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000",
                            {ifc.csr_we, ifc.stall, ifc.flush, ifc.redirect_valid});
        end
        total++;
        if ({ifc.csr_waddr, ifc.csr_wdata, ifc.redirect_pc} !== 76'h0) begin
            bad++; $display("FAIL reset_data: got %h want 0",
                            {ifc.csr_waddr, ifc.csr_wdata, ifc.redirect_pc});
        end
        total++;
        if (ifc.priv !== 2'b11) begin bad++; $display("FAIL reset_priv: got %b want 11", ifc.priv); end
        ifc.exp_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_mret_m;
        drive_req(1'b1, EXP_OP, 4'hE, 32'h80000100, I_MRET, 32'h0, 32'h00000080, 32'h80001000, 32'h80000200);
        total++;
        if ({obs_stall0, 8'(obs_n), obs_addr[0], obs_data[0], 8'(obs_wcyc[0])} !==
            {1'b1, 8'd1, 12'h300, 32'h00000088, 8'd1}) begin
            bad++; $display("FAIL mret_write: got n=%0d %h=%h @%0d want 1 300=00000088 @1",
                            obs_n, obs_addr[0], obs_data[0], obs_wcyc[0]);
        end
        total++;
        if ({8'(obs_rcyc), obs_rpc, obs_priv} !== {8'd2, 32'h80000200, 2'b00}) begin
            bad++; $display("FAIL mret_redirect: got cyc=%0d pc=%h priv=%b want 2 80000200 00",
                            obs_rcyc, obs_rpc, obs_priv);
        end
        total++;
        if (!obs_shape_ok || obs_pulses != 1) begin
            bad++; $display("FAIL mret_shape: got ok=%b pulses=%0d want 1 1", obs_shape_ok, obs_pulses);
        end
    endtask

    task automatic test_misaligned_load;
        logic [11:0] ea [4];
        logic [31:0] ed [4];
        ea = '{12'h341, 12'h342, 12'h343, 12'h300};
        ed = '{32'h80000040, 32'd4, 32'h80000102, 32'h00000080};
        drive_req(1'b1, EXP_ERR, 4'd4, 32'h80000040, 32'h00012083, 32'h80000102,
                  32'h00000008, 32'h80001000, 32'h0);
        total++;
        if (obs_n !== 4 || obs_stall0 !== 1'b1) begin
            bad++; $display("FAIL ld_count: got n=%0d stall0=%b want 4 1", obs_n, obs_stall0);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({obs_addr[i], obs_data[i], 8'(obs_wcyc[i])} !== {ea[i], ed[i], 8'(i + 1)}) begin
                bad++; $display("FAIL ld_write%0d: got %h=%h @%0d want %h=%h @%0d",
                                i, obs_addr[i], obs_data[i], obs_wcyc[i], ea[i], ed[i], i + 1);
            end
        end
        total++;
        if ({8'(obs_rcyc), obs_rpc, obs_priv, obs_shape_ok} !== {8'd5, 32'h80001000, 2'b11, 1'b1}) begin
            bad++; $display("FAIL ld_redirect: got cyc=%0d pc=%h priv=%b ok=%b want 5 80001000 11 1",
                            obs_rcyc, obs_rpc, obs_priv, obs_shape_ok);
        end
    endtask

    task automatic test_ecall;
        drive_req(1'b1, EXP_OP, 4'hE, 32'h0, I_MRET, 32'h0, 32'h0, 32'h0, 32'h80000300);
        total++;
        if (obs_priv !== 2'b00) begin bad++; $display("FAIL ecall_setup_priv: got %b want 00", obs_priv); end
        drive_req(1'b1, EXP_OP, 4'hE, 32'h80000300, I_ECALL, 32'h1234, 32'h0, 32'h80001000, 32'h0);
        total++;
        if ({obs_data[1], obs_data[2], obs_data[3][12:11]} !== {32'd8, 32'd0, 2'b00}) begin
            bad++; $display("FAIL ecall_u: got cause=%h tval=%h mpp=%b want 8 0 00",
                            obs_data[1], obs_data[2], obs_data[3][12:11]);
        end
        drive_req(1'b1, EXP_OP, 4'hE, 32'h80001004, I_ECALL, 32'h1234, 32'h0, 32'h80001000, 32'h0);
        total++;
        if ({obs_data[1], obs_data[2], obs_data[3][12:11]} !== {32'd11, 32'd0, 2'b11}) begin
            bad++; $display("FAIL ecall_m: got cause=%h tval=%h mpp=%b want b 0 11",
                            obs_data[1], obs_data[2], obs_data[3][12:11]);
        end
    endtask

    task automatic test_ebreak;
        drive_req(1'b1, EXP_OP, 4'hE, 32'h80000010, I_EBREAK, 32'hdead, 32'h0, 32'h80001000, 32'h0);
        total++;
        if ({obs_data[0], obs_data[1], obs_data[2]} !== {32'h80000010, 32'd3, 32'h80000010}) begin
            bad++; $display("FAIL ebreak: got epc=%h cause=%h tval=%h want 80000010 3 80000010",
                            obs_data[0], obs_data[1], obs_data[2]);
        end
    endtask

    task automatic test_mret_in_u;
        drive_req(1'b1, EXP_OP, 4'hE, 32'h0, I_MRET, 32'h0, 32'h0, 32'h0, 32'h80000400);
        drive_req(1'b1, EXP_OP, 4'hE, 32'h80000400, I_MRET, 32'h0, 32'h0, 32'h80001000, 32'h0);
        total++;
        if ({8'(obs_n), obs_data[1], obs_data[2], 8'(obs_rcyc), obs_rpc, obs_priv} !==
            {8'd4, 32'd2, 32'h30200073, 8'd5, 32'h80001000, 2'b11}) begin
            bad++; $display("FAIL mret_u: got n=%0d cause=%h tval=%h cyc=%0d pc=%h priv=%b",
                            obs_n, obs_data[1], obs_data[2], obs_rcyc, obs_rpc, obs_priv);
        end
    endtask

    task automatic test_ignored;
        drive_req(1'b1, EXP_OP, 4'hE, 32'h80000500, I_CSRRW, 32'h0, 32'h0, 32'h80001000, 32'h0);
        total++;
        if ({obs_stall0, 8'(obs_n), obs_pulses[7:0]} !== {1'b0, 8'd0, 8'd0}) begin
            bad++; $display("FAIL csrrw_ignored: got stall=%b n=%0d pulses=%0d want 0 0 0",
                            obs_stall0, obs_n, obs_pulses);
        end
        drive_req(1'b1, EXP_ERR, 4'hE, 32'h80000504, 32'h0, 32'h0, 32'h0, 32'h80001000, 32'h0);
        total++;
        if ({obs_stall0, 8'(obs_n), obs_pulses[7:0]} !== {1'b0, 8'd0, 8'd0}) begin
            bad++; $display("FAIL nocause_ignored: got stall=%b n=%0d pulses=%0d want 0 0 0",
                            obs_stall0, obs_n, obs_pulses);
        end
    endtask

    task automatic test_reset_mid;
        drive_req(1'b1, EXP_OP, 4'hE, 32'h0, I_MRET, 32'h0, 32'h0, 32'h0, 32'h80000600);
        @(negedge clk);
        ifc.exp_valid = 1'b1; ifc.exception = EXP_OP; ifc.exp_inst = I_ECALL; ifc.exp_pc = 32'h80000600;
        @(negedge clk) ifc.exp_valid = 1'b0;
        @(negedge clk) #1;
        total++;
        if ({ifc.csr_we, ifc.csr_waddr, ifc.priv} !== {1'b1, 12'h342, 2'b00}) begin
            bad++; $display("FAIL rstmid_pre: got we=%b addr=%h priv=%b want 1 342 00",
                            ifc.csr_we, ifc.csr_waddr, ifc.priv);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({ifc.csr_we, ifc.stall, ifc.flush, ifc.redirect_valid, ifc.csr_waddr,
             ifc.csr_wdata, ifc.redirect_pc, ifc.priv} !== {80'h0, 2'b11}) begin
            bad++; $display("FAIL rstmid_outputs: got we=%b st=%b addr=%h data=%h priv=%b",
                            ifc.csr_we, ifc.stall, ifc.csr_waddr, ifc.csr_wdata, ifc.priv);
        end
        @(negedge clk) rst = 1'b0;
        drive_req(1'b1, EXP_OP, 4'hE, 32'h80000700, I_ECALL, 32'h0, 32'h0, 32'h80001000, 32'h0);
        total++;
        if ({8'(obs_n), obs_addr[0], 8'(obs_wcyc[0]), obs_data[0], obs_data[1]} !==
            {8'd4, 12'h341, 8'd1, 32'h80000700, 32'd11}) begin
            bad++; $display("FAIL rstmid_restart: got n=%0d %h@%0d=%h cause=%h want 4 341@1=80000700 b",
                            obs_n, obs_addr[0], obs_wcyc[0], obs_data[0], obs_data[1]);
        end
    endtask

    task automatic test_random;
        logic v;
        logic [1:0] exc;
        logic [3:0] code;
        logic [31:0] inst, ms;
        int k;
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        mdl_priv = 2'b11;
        for (int it = 0; it < 60; it++) begin
            k = $urandom_range(0, 7);
            v = (k != 7); code = 4'($urandom); exc = EXP_OP; inst = $urandom;
            case (k)
                0: exc = EXP_ERR;
                1: inst = {25'h0, inst[6:0]};
                2: inst = {25'h0002000, inst[6:0]};
                3, 4: inst = {25'h0604000, inst[6:0]};
                5: exc = EXP_NONE;
                6: begin exc = EXP_ERR; code = 4'hE; end
                default: exc = EXP_ERR;
            endcase
            ms = $urandom;
            ms[12:11] = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            begin
                logic [31:0] pc, addr, tvec, epc;
                pc = $urandom; addr = $urandom; tvec = $urandom; epc = $urandom;
                model(v, exc, code, pc, inst, addr, ms, tvec, epc);
                drive_req(v, exc, code, pc, inst, addr, ms, tvec, epc);
            end
            total++;
            if ({obs_stall0, 8'(obs_n), 8'(obs_rcyc), obs_rpc, obs_priv} !==
                {exp_stall0, 8'(exp_n), 8'(exp_rcyc), exp_rpc, exp_priv}) begin
                bad++; $display("FAIL rand%0d_seq: got st=%b n=%0d cyc=%0d pc=%h pr=%b want %b %0d %0d %h %b",
                                it, obs_stall0, obs_n, obs_rcyc, obs_rpc, obs_priv,
                                exp_stall0, exp_n, exp_rcyc, exp_rpc, exp_priv);
            end
            for (int i = 0; i < exp_n; i++) begin
                total++;
                if ({obs_addr[i], obs_data[i], 8'(obs_wcyc[i])} !== {exp_addr[i], exp_data[i], 8'(i + 1)}) begin
                    bad++; $display("FAIL rand%0d_w%0d: got %h=%h @%0d want %h=%h @%0d", it, i,
                                    obs_addr[i], obs_data[i], obs_wcyc[i], exp_addr[i], exp_data[i], i + 1);
                end
            end
            total++;
            if (!obs_shape_ok || obs_pulses != ((exp_rcyc > 0) ? 1 : 0)) begin
                bad++; $display("FAIL rand%0d_shape: got ok=%b pulses=%0d", it, obs_shape_ok, obs_pulses);
            end
        end
    endtask

    initial begin
        test_reset;
        test_mret_m;
        test_misaligned_load;
        test_ecall;
        test_ebreak;
        test_mret_in_u;
        test_ignored;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
